// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: CPU writes feed a small TX FIFO, and an
// IDLE/START/DATA/STOP shifter drives the registered tx pin at a programmable baud.
module uart_tx_periph #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd10415
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  address,
    input  logic [31:0] wData,
    output logic [31:0] rData,
    output logic        tx
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   baud_div_q, baud_div_d;
    logic          enable_q, enable_d;
    logic [15:0]   div_act_q, div_act_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          tx_q, tx_d;

    logic       wr_en, push, push_ok, pop;
    logic       fifo_empty, fifo_full, bit_end, can_start, busy;
    logic [7:0] head;
    logic [3:0] count_field;
    logic       unused_wdata;

    assign wr_en       = sel && we;
    assign push        = wr_en && (address == 2'd1);
    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == DEPTH_C);
    // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a push.
    assign push_ok     = push && !fifo_full;
    assign bit_end     = (baud_cnt_q == div_act_q);
    assign can_start   = enable_q && !fifo_empty;
    assign busy        = (state_q != IDLE);
    assign head        = fifo_mem_q[rd_ptr_q];
    assign count_field = 4'(count_q);
    assign unused_wdata = &{1'b0, wData[31:16]};

    always_comb begin
        baud_div_d = baud_div_q;
        enable_d   = enable_q;
        overflow_d = overflow_q;
        if (wr_en && address == 2'd2) baud_div_d = wData[15:0];
        if (wr_en && address == 2'd3) enable_d = wData[0];
        if (wr_en && address == 2'd0 && wData[3]) overflow_d = 1'b0;
        // Set beats clear when both land on the same edge.
        if (push && fifo_full) overflow_d = 1'b1;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
    end

    always_comb begin
        state_d    = state_q;
        div_act_d  = div_act_q;
        baud_cnt_d = baud_cnt_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        pop        = 1'b0;
        if (state_q != IDLE) baud_cnt_d = bit_end ? 16'd0 : baud_cnt_q + 16'd1;
        case (state_q)
            IDLE: begin
                if (can_start) begin
                    state_d    = START;
                    pop        = 1'b1;
                    shift_d    = head;
                    div_act_d  = baud_div_q;
                    baud_cnt_d = 16'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (can_start) begin
                        state_d   = START;
                        pop       = 1'b1;
                        shift_d   = head;
                        div_act_d = baud_div_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        tx_d = 1'b1;
        if (state_d == START)     tx_d = 1'b0;
        else if (state_d == DATA) tx_d = shift_d[0];
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem_q[wr_ptr_q] <= wData[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            baud_div_q <= DIV_RESET;
            enable_q   <= 1'b0;
            div_act_q  <= DIV_RESET;
            baud_cnt_q <= 16'd0;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            baud_div_q <= baud_div_d;
            enable_q   <= enable_d;
            div_act_q  <= div_act_d;
            baud_cnt_q <= baud_cnt_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        rData = 32'd0;
        case (address)
            2'd0:    rData = {24'd0, count_field, overflow_q, fifo_empty, fifo_full, busy};
            2'd2:    rData = {16'd0, baud_div_q};
            2'd3:    rData = {31'd0, enable_q};
            default: rData = 32'd0;
        endcase
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: register vector table, directed frame-timing sequences and
// randomized traffic checked by a serial line monitor against a queue of expected bytes.
module tb_uart_tx_periph;
    localparam int FIFO_DEPTH = 4;
    localparam logic [15:0] DIV_RESET = 16'd10415;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  address = 2'd0;
    logic [31:0] wData = 32'd0;
    logic [31:0] rData;
    logic        tx;

    uart_tx_periph #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_RESET(DIV_RESET)) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we), .address(address),
        .wData(wData), .rData(rData), .tx(tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: bytes the peripheral should emit, in order, and the
    // divisor that the CPU last programmed.
    logic [7:0] exp_q[$];
    int         model_div = int'(DIV_RESET);
    int         frames_done = 0;
    int         starts[$];
    logic       chk_en = 1'b1;

    typedef struct {
        logic        do_wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; we = 1'b1; address = a; wData = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0; wData = 32'd0;
        if (a == 2'd2) model_div = int'(d[15:0]);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = rData;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frames_done", 32'(frames_done), 32'(n));
    endtask

    task automatic wait_idle_status();
        logic [31:0] st;
        @(negedge clk);
        @(negedge clk);
        rd(2'd0, st);
        chk("status_idle", st, 32'h4);
        chk("model_queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Line monitor: a frame is a low start bit, 8 LSB-first data bits and a high stop
    // bit, each (div+1) clocks long, using the divisor in force when the frame began.
    initial begin : monitor
        int         cyc_no;
        logic       in_frame;
        logic [7:0] f_byte, f_dec;
        int         f_div, f_cyc, f_errs, per, bidx;
        logic       expbit;
        cyc_no = 0; in_frame = 1'b0;
        f_byte = 8'd0; f_dec = 8'd0; f_div = 0; f_cyc = 0; f_errs = 0; per = 1; bidx = 0;
        forever begin
            @(negedge clk);
            cyc_no++;
            if (reset || !chk_en) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && tx == 1'b0) begin
                    starts.push_back(cyc_no);
                    chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) f_byte = exp_q.pop_front();
                    else f_byte = 8'h00;
                    f_div = model_div; in_frame = 1'b1;
                    f_cyc = 0; f_errs = 0; f_dec = 8'd0;
                end
                if (in_frame) begin
                    per  = f_div + 1;
                    bidx = f_cyc / per;
                    if (bidx == 0)      expbit = 1'b0;
                    else if (bidx <= 8) expbit = f_byte[bidx-1];
                    else                expbit = 1'b1;
                    if (tx !== expbit) f_errs++;
                    if (bidx >= 1 && bidx <= 8 && (f_cyc % per) == per / 2) f_dec[bidx-1] = tx;
                    f_cyc++;
                    if (f_cyc == 10 * per) begin
                        $display("frame %0d: byte 0x%02h div %0d decoded 0x%02h", frames_done, f_byte, f_div, f_dec);
                        chk("frame_bits", 32'(f_errs), 32'd0);
                        chk("frame_byte", {24'd0, f_dec}, {24'd0, f_byte});
                        frames_done++;
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] st;
        int lows, busys, target, n, cnt, div;
        logic [7:0] b;

        vecs[0] = '{1'b0, 2'd0, 32'd0,          2'd0, 32'h4};
        vecs[1] = '{1'b0, 2'd0, 32'd0,          2'd1, 32'h0};
        vecs[2] = '{1'b0, 2'd0, 32'd0,          2'd2, 32'd10415};
        vecs[3] = '{1'b0, 2'd0, 32'd0,          2'd3, 32'h0};
        vecs[4] = '{1'b1, 2'd2, 32'hDEAD1234,   2'd2, 32'h1234};
        vecs[5] = '{1'b1, 2'd3, 32'hFFFFFFFE,   2'd3, 32'h0};
        vecs[6] = '{1'b1, 2'd3, 32'h00000003,   2'd3, 32'h1};
        vecs[7] = '{1'b1, 2'd0, 32'hFFFFFFFF,   2'd0, 32'h4};
        vecs[8] = '{1'b1, 2'd2, 32'h00000003,   2'd2, 32'h3};
        vecs[9] = '{1'b1, 2'd3, 32'h00000001,   2'd0, 32'h4};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);

        // Register map vectors (reset values first, then write/readback).
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].waddr, vecs[i].wdata);
            rd(vecs[i].raddr, st);
            $display("vec %0d: addr %0d read 0x%0h", i, vecs[i].raddr, st);
            chk($sformatf("vec%0d", i), st, vecs[i].exp);
        end

        // 0xA5 at div 3 with enable already set: 40-clock frame, busy throughout.
        exp_q.push_back(8'hA5);
        bus_write(2'd1, 32'hA5);
        rd(2'd0, st);
        chk("status_after_push", st, 32'h10);
        chk("tx_before_pop", 32'(tx), 32'd1);
        lows = 0; busys = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            rd(2'd0, st);
            if (tx == 1'b0) lows++;
            if (st[0]) busys++;
        end
        chk("a5_busy_cycles", 32'(busys), 32'd40);
        chk("a5_low_cycles", 32'(lows), 32'd20);
        chk("a5_frames", 32'(frames_done), 32'd1);
        rd(2'd0, st);
        chk("a5_status_after", st, 32'h4);

        // Div 0, three bytes back to back: contiguous 10-clock frames.
        bus_write(2'd2, 32'd0);
        starts.delete();
        target = frames_done + 3;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(8'(i));
            bus_write(2'd1, 32'(i));
        end
        for (int k = 0; k < 200 && starts.size() < 3; k++) begin
            @(negedge clk);
            #3;
        end
        rd(2'd0, st);
        chk("empty_after_third_pop", st, 32'h5);
        wait_frames(target, 500);
        if (starts.size() >= 3) begin
            chk("b2b_gap1", 32'(starts[1] - starts[0]), 32'd10);
            chk("b2b_gap2", 32'(starts[2] - starts[1]), 32'd10);
        end else begin
            chk("b2b_starts", 32'(starts.size()), 32'd3);
        end
        wait_idle_status();

        // Disabled: five writes into a 4-deep FIFO, overflow, clear, then drain.
        bus_write(2'd3, 32'd0);
        bus_write(2'd2, 32'd1);
        lows = 0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= FIFO_DEPTH) exp_q.push_back(8'(i));
            bus_write(2'd1, 32'(i));
            if (tx == 1'b0) lows++;
        end
        rd(2'd0, st);
        chk("ovf_status", st, 32'h4A);
        chk("ovf_tx_idle", 32'(lows + (tx ? 0 : 1)), 32'd0);
        bus_write(2'd0, 32'h0);
        rd(2'd0, st);
        chk("ovf_no_clear_bit3_0", st, 32'h4A);
        bus_write(2'd0, 32'h8);
        rd(2'd0, st);
        chk("ovf_cleared", st, 32'h42);
        target = frames_done + 4;
        bus_write(2'd3, 32'd1);
        wait_frames(target, 1000);
        wait_idle_status();

        // Div 2 frame, BAUDDIV rewritten to 5 mid-frame: only the next byte slows down.
        bus_write(2'd2, 32'd2);
        starts.delete();
        target = frames_done + 2;
        exp_q.push_back(8'h55);
        bus_write(2'd1, 32'h55);
        repeat (8) @(negedge clk);
        bus_write(2'd2, 32'd5);
        exp_q.push_back(8'h66);
        bus_write(2'd1, 32'h66);
        wait_frames(target, 1000);
        if (starts.size() >= 2) chk("div_change_gap", 32'(starts[1] - starts[0]), 32'd30);
        else chk("div_change_starts", 32'(starts.size()), 32'd2);
        wait_idle_status();

        // Randomized traffic against the queue model.
        for (int it = 0; it < 8; it++) begin
            div = int'($urandom_range(0, 3));
            bus_write(2'd2, 32'(div));
            if (it % 2 == 0) begin
                bus_write(2'd3, 32'd1);
                n = int'($urandom_range(1, FIFO_DEPTH));
                target = frames_done + n;
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    bus_write(2'd1, {24'd0, b});
                end
            end else begin
                bus_write(2'd3, 32'd0);
                n = int'($urandom_range(1, FIFO_DEPTH + 2));
                for (int i = 0; i < n; i++) begin
                    b = 8'($urandom);
                    if (i < FIFO_DEPTH) exp_q.push_back(b);
                    bus_write(2'd1, {24'd0, b});
                end
                cnt = (n < FIFO_DEPTH) ? n : FIFO_DEPTH;
                rd(2'd0, st);
                chk($sformatf("rand%0d_status", it), st,
                    32'((cnt << 4) + ((n > FIFO_DEPTH) ? 8 : 0) + ((cnt == FIFO_DEPTH) ? 2 : 0)));
                target = frames_done + cnt;
                bus_write(2'd0, 32'h8);
                bus_write(2'd3, 32'd1);
            end
            $display("rand %0d: div %0d bytes %0d", it, div, n);
            wait_frames(target, 2000);
            wait_idle_status();
        end

        // Reset in the middle of DATA with two bytes still queued.
        bus_write(2'd2, 32'd3);
        bus_write(2'd3, 32'd1);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'hF0 + 8'(i));
            bus_write(2'd1, 32'hF0 + 32'(i));
        end
        repeat (10) @(negedge clk);
        chk_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        rd(2'd0, st);
        chk("rst_status", st, 32'h4);
        reset = 1'b0;
        model_div = int'(DIV_RESET);
        chk_en = 1'b1;
        rd(2'd2, st);
        chk("rst_bauddiv", st, 32'd10415);
        target = frames_done;
        bus_write(2'd3, 32'd1);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        chk("rst_no_frames", 32'(lows), 32'd0);
        chk("rst_frame_count", 32'(frames_done), 32'(target));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
